// File: rtl/sd_card_cmd_responder_pkg.sv
// ---------------------------------------------------------------------------
// sd_cmd_pkg
// Shared definitions for the SD CMD-line responder:
//   - FSM state encoding
//   - frame lengths and CRC7 field positions
//   - a one-step serial CRC7 helper (x^7 + x^3 + 1, init 0)
// ---------------------------------------------------------------------------
package sd_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RX,
      CHECK,
      PRESENT,
      WAIT_RSP,
      NCR_WAIT,
      TX
   } sd_cmd_state_t;

   localparam int CMD_LEN       = 48;
   localparam int RSP_SHORT_LEN = 48;
   localparam int RSP_LONG_LEN  = 136;

   localparam logic [6:0] CRC7_POLY = 7'h09;

   // Bit positions (counted from the first transmitted bit) where the CRC
   // coverage starts and where the CRC field itself starts.
   localparam int SHORT_COVER_START = 0;
   localparam int SHORT_CRC_START   = 40;
   localparam int LONG_COVER_START  = 8;
   localparam int LONG_CRC_START    = 128;

   // One serial CRC7 step. Feeding the current crc[6] back in gives fb=0,
   // which simply shifts the register left; the transmitter relies on this
   // to shift the finished CRC out of the same register.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
      logic fb;
      fb = bit_in ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_card_cmd_responder_if.sv
// ---------------------------------------------------------------------------
// sd_card_cmd_responder_if
// Handshake bundle between the CMD-line responder and the card logic.
//   cmd_valid/cmd_ack   : decoded command offered to the card logic
//   cmd_index/cmd_arg   : decoded command fields
//   crc_error           : one-cycle pulse on a rejected frame
//   rsp_valid/rsp_none  : card logic supplies a response / declares none
//   rsp_long            : 1 = 136-bit R2, 0 = 48-bit response
//   rsp_index/rsp_data  : response fields
// Modports:
//   master : card logic side (consumes commands, produces responses)
//   slave  : responder side
// ---------------------------------------------------------------------------
interface sd_card_cmd_responder_if;

   logic         cmd_valid;
   logic         cmd_ack;
   logic [5:0]   cmd_index;
   logic [31:0]  cmd_arg;
   logic         crc_error;
   logic         rsp_valid;
   logic         rsp_none;
   logic         rsp_long;
   logic [5:0]   rsp_index;
   logic [119:0] rsp_data;

   modport master (
      input  cmd_valid, cmd_index, cmd_arg, crc_error,
      output cmd_ack, rsp_valid, rsp_none, rsp_long, rsp_index, rsp_data
   );

   modport slave (
      output cmd_valid, cmd_index, cmd_arg, crc_error,
      input  cmd_ack, rsp_valid, rsp_none, rsp_long, rsp_index, rsp_data
   );

endinterface

// File: rtl/sd_card_cmd_responder_crc7.sv
// ---------------------------------------------------------------------------
// sd_crc7
// Serial CRC7 generator/checker (x^7 + x^3 + 1, init 0).
// Ports:
//   sd_clock : clock
//   reset    : synchronous, active-high
//   clear    : return the register to 0 (wins over enable)
//   enable   : advance the CRC by one bit
//   bit_in   : serial data bit
//   crc      : current CRC7 value
// ---------------------------------------------------------------------------
module sd_crc7
   import sd_cmd_pkg::*;
(
   input  logic       sd_clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       enable,
   input  logic       bit_in,
   output logic [6:0] crc
);

   // CRC register: cleared between frames, advanced one bit per enabled cycle.
   always_ff @(posedge sd_clock) begin
      if (reset || clear) begin
         crc <= 7'h00;
      end else if (enable) begin
         crc <= crc7_step(crc, bit_in);
      end
   end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// ---------------------------------------------------------------------------
// sd_card_cmd_responder
// Card-side endpoint of the SD CMD line. Receives 48-bit host commands,
// checks framing and CRC7, offers index/argument to the card logic and
// serializes the short (48-bit) or long (136-bit) response with CRC7.
// Parameters:
//   NCR         : idle cycles between latching a response and its start bit (2..64)
//   RSP_TIMEOUT : cycles allowed in WAIT_RSP before silently returning to IDLE
// Ports:
//   sd_clock : clock, CMD sampled and driven on the rising edge
//   reset    : synchronous, active-high
//   cmd_in   : CMD line as seen from the pad
//   cmd_out  : serial response bit (1 when not driving)
//   cmd_oe   : pad output enable, high only while a response bit is driven
//   busy     : high in every state except IDLE
//   card     : handshake bundle to the card logic (slave modport)
// ---------------------------------------------------------------------------
module sd_card_cmd_responder
   import sd_cmd_pkg::*;
#(
   parameter int NCR         = 2,
   parameter int RSP_TIMEOUT = 64
) (
   input  logic                        sd_clock,
   input  logic                        reset,
   input  logic                        cmd_in,
   output logic                        cmd_out,
   output logic                        cmd_oe,
   output logic                        busy,
   sd_card_cmd_responder_if.slave      card
);

   sd_cmd_state_t state;
   sd_cmd_state_t next_state;

   // One counter serves every state: RX bit countdown, WAIT_RSP timeout,
   // NCR gap and TX bit position. Each state reloads it on entry.
   logic [7:0]   cnt;
   logic [47:0]  rx_shift;
   logic [135:0] tx_shift;
   logic         tx_long;
   logic [5:0]   cmd_index_q;
   logic [31:0]  cmd_arg_q;
   logic         crc_error_q;

   logic [6:0]   rx_crc;
   logic [6:0]   tx_crc;
   logic         rx_crc_en;
   logic         tx_crc_en;
   logic         frame_ok;
   logic [7:0]   tx_last;
   logic [7:0]   tx_cover_start;
   logic [7:0]   tx_crc_start;
   logic         in_crc_field;
   logic         tx_bit;

   // The start bit (frame bit 47) is 0 by construction and leaves the
   // init-0 CRC unchanged, so the RX CRC only runs over bits 46..8.
   assign rx_crc_en = (state == RX) && (cnt >= 8'd9);

   sd_crc7 u_rx_crc (
      .sd_clock (sd_clock),
      .reset    (reset),
      .clear    (state == IDLE),
      .enable   (rx_crc_en),
      .bit_in   (cmd_in),
      .crc      (rx_crc)
   );

   sd_crc7 u_tx_crc (
      .sd_clock (sd_clock),
      .reset    (reset),
      .clear    (state != TX),
      .enable   (tx_crc_en),
      .bit_in   (tx_bit),
      .crc      (tx_crc)
   );

   // Frame acceptance and TX field positions.
   always_comb begin
      frame_ok       = (rx_shift[47] == 1'b0) && rx_shift[46] &&
                       (rx_shift[7:1] == rx_crc) && rx_shift[0];
      tx_last        = tx_long ? 8'(RSP_LONG_LEN - 1)  : 8'(RSP_SHORT_LEN - 1);
      tx_cover_start = tx_long ? 8'(LONG_COVER_START)  : 8'(SHORT_COVER_START);
      tx_crc_start   = tx_long ? 8'(LONG_CRC_START)    : 8'(SHORT_CRC_START);
      in_crc_field   = (cnt >= tx_crc_start) && (cnt < tx_crc_start + 8'd7);
      // Inside the CRC field the bit comes from the CRC register; feeding it
      // back into the generator shifts the CRC out MSB-first.
      tx_bit         = in_crc_field ? tx_crc[6] : tx_shift[135];
      tx_crc_en      = (state == TX) && (cnt >= tx_cover_start) &&
                       (cnt < tx_crc_start + 8'd7);
   end

   // State register.
   always_ff @(posedge sd_clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (!cmd_in) next_state = RX;
         RX:       if (cnt == 8'd1) next_state = CHECK;
         CHECK:    next_state = frame_ok ? PRESENT : IDLE;
         PRESENT:  if (card.cmd_ack) next_state = WAIT_RSP;
         WAIT_RSP: begin
            if (card.rsp_none) begin
               next_state = IDLE;
            end else if (card.rsp_valid) begin
               next_state = NCR_WAIT;
            end else if (cnt == 8'(RSP_TIMEOUT - 1)) begin
               next_state = IDLE;
            end
         end
         NCR_WAIT: if (cnt == 8'(NCR - 1)) next_state = TX;
         TX:       if (cnt == tx_last) next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Datapath: shift registers, counter, latched command fields and the
   // crc_error pulse. The counter saturates rather than wrapping.
   always_ff @(posedge sd_clock) begin
      if (reset) begin
         cnt         <= 8'd0;
         rx_shift    <= 48'd0;
         tx_shift    <= 136'd0;
         tx_long     <= 1'b0;
         cmd_index_q <= 6'd0;
         cmd_arg_q   <= 32'd0;
         crc_error_q <= 1'b0;
      end else begin
         crc_error_q <= 1'b0;
         case (state)
            IDLE: begin
               rx_shift <= {rx_shift[46:0], cmd_in};
               cnt      <= 8'(CMD_LEN - 1);
            end
            RX: begin
               rx_shift <= {rx_shift[46:0], cmd_in};
               if (cnt != 8'd0) cnt <= cnt - 8'd1;
            end
            CHECK: begin
               if (frame_ok) begin
                  cmd_index_q <= rx_shift[45:40];
                  cmd_arg_q   <= rx_shift[39:8];
               end else begin
                  crc_error_q <= 1'b1;
               end
            end
            PRESENT: cnt <= 8'd0;
            WAIT_RSP: begin
               if (next_state == NCR_WAIT) begin
                  cnt     <= 8'd0;
                  tx_long <= card.rsp_long;
                  // CRC slot is left as zeros and filled on the fly in TX.
                  if (card.rsp_long) begin
                     tx_shift <= {2'b00, 6'b111111, card.rsp_data, 7'd0, 1'b1};
                  end else begin
                     tx_shift <= {2'b00, card.rsp_index, card.rsp_data[31:0],
                                  7'd0, 1'b1, 88'd0};
                  end
               end else if (cnt != 8'hFF) begin
                  cnt <= cnt + 8'd1;
               end
            end
            NCR_WAIT: begin
               if (next_state == TX) begin
                  cnt <= 8'd0;
               end else if (cnt != 8'hFF) begin
                  cnt <= cnt + 8'd1;
               end
            end
            TX: begin
               tx_shift <= {tx_shift[134:0], 1'b0};
               if (cnt != 8'hFF) cnt <= cnt + 8'd1;
            end
            default: cnt <= 8'd0;
         endcase
      end
   end

   assign cmd_oe         = (state == TX);
   assign cmd_out        = (state == TX) ? tx_bit : 1'b1;
   assign busy           = (state != IDLE);
   assign card.cmd_valid = (state == PRESENT);
   assign card.cmd_index = cmd_index_q;
   assign card.cmd_arg   = cmd_arg_q;
   assign card.crc_error = crc_error_q;

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// ---------------------------------------------------------------------------
// tb_sd_card_cmd_responder
// Directed bench for sd_card_cmd_responder: drives host command frames on
// cmd_in, plays the card logic through the interface and compares decoded
// fields and serialized responses against hand-computed frames.
// Inputs change and outputs are sampled just after the falling edge.
// ---------------------------------------------------------------------------
module tb_sd_card_cmd_responder;

   logic sd_clock = 1'b0;
   logic reset;
   logic cmd_in;
   logic cmd_out;
   logic cmd_oe;
   logic busy;

   int checks   = 0;
   int failures = 0;

   logic [135:0] rsp_bits;
   logic         oe_all;
   logic         oe_any;

   sd_card_cmd_responder_if bus();

   sd_card_cmd_responder #(
      .NCR         (2),
      .RSP_TIMEOUT (64)
   ) dut (
      .sd_clock (sd_clock),
      .reset    (reset),
      .cmd_in   (cmd_in),
      .cmd_out  (cmd_out),
      .cmd_oe   (cmd_oe),
      .busy     (busy),
      .card     (bus)
   );

   always #5 sd_clock = ~sd_clock;

   // Compare one observed value with its expected value.
   task automatic checkOutput(input string tag, input logic [135:0] observed,
                              input logic [135:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Shift a 48-bit host frame onto cmd_in, MSB first.
   task automatic applyStimulus(input logic [47:0] frame);
      for (int i = 47; i >= 0; i--) begin
         cmd_in = frame[i];
         @(negedge sd_clock);
      end
      cmd_in = 1'b1;
   endtask

   // Capture n response bits, tracking whether cmd_oe stayed high.
   task automatic collectResponse(input int n, output logic [135:0] bits,
                                  output logic oe_high);
      bits    = '0;
      oe_high = 1'b1;
      for (int i = 0; i < n; i++) begin
         bits    = {bits[134:0], cmd_out};
         oe_high = oe_high & cmd_oe;
         @(negedge sd_clock);
      end
   endtask

   // Watch cmd_oe for n cycles; report whether it ever rose.
   task automatic watchIdle(input int n, output logic oe_seen);
      oe_seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         oe_seen = oe_seen | cmd_oe;
         @(negedge sd_clock);
      end
   endtask

   task automatic ackCommand();
      bus.cmd_ack = 1'b1;
      @(negedge sd_clock);
      bus.cmd_ack = 1'b0;
   endtask

   // Drive a response in WAIT_RSP and step through the NCR gap.
   task automatic giveResponse(input logic is_long, input logic [5:0] idx,
                               input logic [119:0] data, input string tag);
      bus.rsp_long  = is_long;
      bus.rsp_index = idx;
      bus.rsp_data  = data;
      bus.rsp_valid = 1'b1;
      @(negedge sd_clock);
      bus.rsp_valid = 1'b0;
      checkOutput({tag, "_ncr0_oe"}, cmd_oe, 1'b0);
      checkOutput({tag, "_ncr0_out"}, cmd_out, 1'b1);
      @(negedge sd_clock);
      checkOutput({tag, "_ncr1_oe"}, cmd_oe, 1'b0);
      @(negedge sd_clock);
   endtask

   // Global time limit so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset         = 1'b1;
      cmd_in        = 1'b1;
      bus.cmd_ack   = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_none  = 1'b0;
      bus.rsp_long  = 1'b0;
      bus.rsp_index = 6'd0;
      bus.rsp_data  = 120'd0;
      repeat (3) @(negedge sd_clock);

      // Reset values
      checkOutput("rst_cmd_out",   cmd_out,       1'b1);
      checkOutput("rst_cmd_oe",    cmd_oe,        1'b0);
      checkOutput("rst_valid",     bus.cmd_valid, 1'b0);
      checkOutput("rst_crc_error", bus.crc_error, 1'b0);
      checkOutput("rst_index",     bus.cmd_index, 6'd0);
      checkOutput("rst_arg",       bus.cmd_arg,   32'd0);
      checkOutput("rst_busy",      busy,          1'b0);
      reset = 1'b0;
      @(negedge sd_clock);

      // cmd_ack while idle is ignored
      ackCommand();
      checkOutput("idle_ack_busy", busy, 1'b0);

      // CMD0, no response
      applyStimulus(48'h400000000095);
      @(negedge sd_clock);
      checkOutput("cmd0_valid", bus.cmd_valid, 1'b1);
      checkOutput("cmd0_index", bus.cmd_index, 6'd0);
      checkOutput("cmd0_arg",   bus.cmd_arg,   32'd0);
      checkOutput("cmd0_crcerr", bus.crc_error, 1'b0);
      ackCommand();
      checkOutput("cmd0_valid_drop", bus.cmd_valid, 1'b0);
      bus.rsp_none = 1'b1;
      @(negedge sd_clock);
      bus.rsp_none = 1'b0;
      checkOutput("cmd0_none_busy", busy, 1'b0);
      watchIdle(8, oe_any);
      checkOutput("cmd0_no_oe", oe_any, 1'b0);

      // CMD8 with R7 short response
      applyStimulus(48'h48000001AA87);
      @(negedge sd_clock);
      checkOutput("cmd8_valid", bus.cmd_valid, 1'b1);
      checkOutput("cmd8_index", bus.cmd_index, 6'd8);
      checkOutput("cmd8_arg",   bus.cmd_arg,   32'h000001AA);
      repeat (3) @(negedge sd_clock);
      checkOutput("cmd8_hold_valid", bus.cmd_valid, 1'b1);
      checkOutput("cmd8_hold_index", bus.cmd_index, 6'd8);
      ackCommand();
      giveResponse(1'b0, 6'd8, 120'h1AA, "r7");
      collectResponse(48, rsp_bits, oe_all);
      checkOutput("r7_stream", rsp_bits, 136'h08000001AA13);
      checkOutput("r7_oe_high", oe_all, 1'b1);
      checkOutput("r7_oe_release", cmd_oe, 1'b0);
      checkOutput("r7_out_release", cmd_out, 1'b1);
      checkOutput("r7_busy_end", busy, 1'b0);

      // CMD8 with corrupted CRC byte, then CMD17 back-to-back
      applyStimulus(48'h48000001AA86);
      @(negedge sd_clock);
      checkOutput("bad_crc_pulse", bus.crc_error, 1'b1);
      checkOutput("bad_crc_valid", bus.cmd_valid, 1'b0);
      checkOutput("bad_crc_busy",  busy, 1'b0);
      @(negedge sd_clock);
      checkOutput("bad_crc_pulse_end", bus.crc_error, 1'b0);
      applyStimulus(48'h510000000055);
      @(negedge sd_clock);
      checkOutput("cmd17_valid", bus.cmd_valid, 1'b1);
      checkOutput("cmd17_index", bus.cmd_index, 6'd17);
      checkOutput("cmd17_arg",   bus.cmd_arg,   32'd0);

      // Long R2 response with an all-zero body
      ackCommand();
      giveResponse(1'b1, 6'd0, 120'd0, "r2");
      collectResponse(136, rsp_bits, oe_all);
      checkOutput("r2_stream", rsp_bits, {2'b00, 6'b111111, 120'd0, 7'd0, 1'b1});
      checkOutput("r2_oe_high", oe_all, 1'b1);
      checkOutput("r2_oe_release", cmd_oe, 1'b0);
      bus.rsp_long = 1'b0;

      // rsp_valid and rsp_none together: rsp_none wins
      applyStimulus(48'h400000000095);
      @(negedge sd_clock);
      ackCommand();
      bus.rsp_valid = 1'b1;
      bus.rsp_none  = 1'b1;
      @(negedge sd_clock);
      bus.rsp_valid = 1'b0;
      bus.rsp_none  = 1'b0;
      checkOutput("both_busy", busy, 1'b0);
      watchIdle(8, oe_any);
      checkOutput("both_no_oe", oe_any, 1'b0);

      // Reset in the middle of a response
      applyStimulus(48'h48000001AA87);
      @(negedge sd_clock);
      ackCommand();
      giveResponse(1'b0, 6'd8, 120'h1AA, "rst_tx");
      collectResponse(20, rsp_bits, oe_all);
      checkOutput("rst_tx_prefix", rsp_bits, 136'h08000);
      checkOutput("rst_tx_oe_before", cmd_oe, 1'b1);
      reset = 1'b1;
      @(negedge sd_clock);
      reset = 1'b0;
      checkOutput("rst_tx_oe", cmd_oe, 1'b0);
      checkOutput("rst_tx_busy", busy, 1'b0);
      checkOutput("rst_tx_out", cmd_out, 1'b1);
      checkOutput("rst_tx_index", bus.cmd_index, 6'd0);

      // Stalled WAIT_RSP times out after exactly 64 cycles
      applyStimulus(48'h400000000095);
      @(negedge sd_clock);
      ackCommand();
      repeat (63) @(negedge sd_clock);
      checkOutput("timeout_busy_63", busy, 1'b1);
      @(negedge sd_clock);
      checkOutput("timeout_busy_64", busy, 1'b0);
      checkOutput("timeout_no_pulse", bus.crc_error, 1'b0);
      checkOutput("timeout_oe", cmd_oe, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sd_card_cmd_responder.md
Name: sd_card_cmd_responder

Overview:
- Card-side endpoint of the SD CMD line.
- Deserializes 48-bit host commands and checks framing and CRC7.
- Hands the index and argument to card logic through a valid/ack handshake.
- Serializes the 48-bit (short) or 136-bit (long) response back onto CMD with a generated CRC7; acts as the bench/model counterpart of the host command controller.

Parameters:
- NCR, 2, idle cycles (CMD released high) between latching the response and driving its start bit; legal range 2..64.
- RSP_TIMEOUT, 64, sd_clock cycles allowed in WAIT_RSP before giving up silently.

Ports:
- sd_clock  in  1  clock; CMD sampled and driven on rising edge
- reset  in  1  synchronous, active-high
- cmd_in  in  1  CMD line as seen from the pad
- cmd_out  out  1  serial response bit
- cmd_oe  out  1  pad output enable; 1 only while a response bit is driven
- cmd_valid  out  1  a decoded command is held on cmd_index/cmd_arg
- cmd_ack  in  1  card logic accepted the command
- cmd_index  out  6  command index
- cmd_arg  out  32  command argument
- crc_error  out  1  one-cycle pulse on a bad frame
- rsp_valid  in  1  response data is present (sampled in WAIT_RSP)
- rsp_none  in  1  the command has no response (sampled in WAIT_RSP)
- rsp_long  in  1  1 = 136-bit R2, 0 = 48-bit
- rsp_index  in  6  index field for a short response
- rsp_data  in  120  short: [31:0] payload; long: [119:0] CID/CSD body
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: cmd_out=1, cmd_oe=0, cmd_valid=0, crc_error=0, cmd_index=0, cmd_arg=0, busy=0, state=IDLE.
- Reset asserted mid-transfer aborts it; cmd_oe=0 from the next edge.
- IDLE: cmd_in==0 is the start bit. Go to RX; the bit counter is loaded to 47.
- RX: shift cmd_in MSB-first into a 48-bit register (start bit included). The serial CRC7 runs over frame bits 47..8. After bit 0 is sampled, go to CHECK (frame complete 48 cycles after the start bit).
- CHECK (1 cycle) requires all of:
  - bit46 (transmission bit) == 1
  - bits[7:1] == computed CRC7
  - bit0 (end bit) == 1
- CHECK fail: crc_error pulses 1 cycle, return to IDLE. cmd_valid is not raised.
- CHECK pass: latch cmd_index=bits[45:40], cmd_arg=bits[39:8], raise cmd_valid, go to PRESENT.
- PRESENT: hold cmd_valid=1 and fields stable until cmd_ack=1. At that edge, drop cmd_valid and go to WAIT_RSP. cmd_ack outside PRESENT is ignored.
- WAIT_RSP:
  - rsp_none=1 → IDLE. rsp_none takes priority over a simultaneous rsp_valid.
  - else rsp_valid=1 → latch the response into the shift register, go to NCR_WAIT.
  - RSP_TIMEOUT cycles with neither → IDLE, no pulse.
- NCR_WAIT: cmd_oe=0 for exactly NCR cycles, then TX.
- Response frame, shifted MSB-first:
  - Short (48 bits): 0, 0, rsp_index, rsp_data[31:0], CRC7, 1.
  - Long (136 bits): 0, 0, 111111, rsp_data[119:0], CRC7, 1.
- CRC7 coverage: short = first 40 bits; long = the 120 body bits only.
- TX: cmd_oe=1. Each cycle drive one bit. The CRC is appended on the fly once the covered bits are sent.
- After the end bit, release the line (cmd_oe=0, cmd_out=1) and return to IDLE. Back-to-back commands are accepted from that cycle.
- CMD-line activity during PRESENT/WAIT_RSP/NCR_WAIT/TX is ignored; there is no collision detection.
- CRC7 is polynomial x^7+x^3+1 with init 0; serial update uses fb = bit ^ crc[6].
- All counters saturate at their terminal value and never wrap.

Decomposition:
- Package sd_cmd_pkg holds:
  - state encoding: IDLE, RX, CHECK, PRESENT, WAIT_RSP, NCR_WAIT, TX
  - CMD_LEN=48, RSP_SHORT_LEN=48, RSP_LONG_LEN=136, CRC7_POLY=7'h09
- Sub-module sd_crc7: serial CRC7 with clear/enable/bit inputs and a 7-bit output. Instanced twice, once for RX and once for TX.

Test Plan:
- Serial 0x400000000095 (CMD0) → cmd_valid=1, cmd_index=0, cmd_arg=0, crc_error=0. Assert rsp_none → IDLE and cmd_oe never rises.
- Serial 0x48000001AA87 (CMD8) → cmd_index=8, cmd_arg=0x000001AA. Ack, then rsp_index=8, rsp_data[31:0]=0x000001AA, rsp_long=0 → after NCR=2 idle cycles, cmd_out streams 0x08000001AA13 over 48 cycles with cmd_oe=1, then cmd_oe=0.
- Same CMD8 frame with the CRC byte 0x86 → single crc_error pulse, cmd_valid stays 0. A following valid 0x510000000055 decodes as index 17.
- rsp_long=1 with body 120'h0 → 136-bit stream: 0, 0, 111111, 120 zeros, CRC7=0000000, 1. rsp_valid and rsp_none set together → no transmission.
- Reset asserted at TX bit 20 → cmd_oe=0, busy=0 next edge. Stalled WAIT_RSP → IDLE after exactly 64 cycles.
